ble_aa_packet_deframer: RTL
===========================

Name: ble_aa_packet_deframer

Overview:
Downstream stage of the BLE matched-filter demodulator. Consumes the hard-decision bit stream, one bit per update strobe (1 Mbps at 16 MHz clk). Searches for the 32-bit access address (AA) with a Hamming-distance tolerance, then dewhitens the following PDU and emits it LSB-first as bytes. Frame length comes from the PDU header, plus 3 CRC bytes. Output feeds the CRC/packet-buffer stage.

Parameters:
MAX_MISMATCH, 1, maximum AA bit errors accepted (0..4)
MAX_LEN, 255, largest accepted header length field; larger aborts the frame
CRC_BYTES, 3, trailing bytes emitted after the payload

Ports:
clk  in  1  16 MHz system clock
rst  in  1  asynchronous, active-low reset
en  in  1  search/receive enable; low forces IDLE-in-SEARCH
bit_valid  in  1  one-cycle strobe: bit_in is valid this cycle
bit_in  in  1  demodulated bit, over-the-air order
access_addr  in  32  target AA, bit0 transmitted first
channel  in  6  BLE channel index, used for whitening seed
dewhiten_en  in  1  1 = XOR whitening sequence onto PDU bits
aa_found  out  1  one-cycle pulse on AA match
byte_out  out  8  assembled PDU byte, held until next byte
byte_valid  out  1  one-cycle pulse, byte_out new this cycle
pkt_done  out  1  one-cycle pulse coincident with the last byte or an abort
pkt_err  out  1  valid with pkt_done: 1 = length abort

Behaviour:
- Reset: all outputs 0, AA shift register 0, state SEARCH, counters 0, LFSR 0.
- Decided: reset rst, asynchronous, active-low; clock clk.
- No backpressure. Bits may arrive on consecutive clocks or sparsely. Nothing advances when bit_valid=0.
- The AA shift register is 32 bits and updates only in SEARCH on bit_valid: sr <= {bit_in, sr[31:1]}.
- Match = popcount({bit_in, sr[31:1]} ^ access_addr) <= MAX_MISMATCH, evaluated in the bit_valid cycle. aa_found is registered high the next cycle. State goes to HDR0, and the LFSR and bit/byte counters are initialised.
- Match is checked only once at least 32 bits have been shifted since entering SEARCH; a 6-bit fill counter saturates at 32.
- Whitening LFSR w[6:0] (position k = w[k]):
  - init w[0]=1, w[1]=channel[5], w[2]=channel[4], w[3]=channel[3], w[4]=channel[2], w[5]=channel[1], w[6]=channel[0].
  - Per PDU bit: wbit=w[6]; next w[0]=w[6], w[4]=w[3]^w[6], other w[k]=w[k-1] (x^7+x^4+1).
  - dbit = bit_in ^ (dewhiten_en & wbit). The LFSR steps on every PDU bit regardless of dewhiten_en.
- Byte assembly: bsh <= {dbit, bsh[7:1]}. On the 8th bit, byte_out <= {dbit, bsh[7:1]} and byte_valid pulses the next cycle.
- States:
  - SEARCH: hunt for AA.
  - HDR0: first header byte. On completion, go to HDR1.
  - HDR1: on completion, len <= byte. If len > MAX_LEN: byte still emitted, pkt_done=1 and pkt_err=1 with it, go to SEARCH. Otherwise remaining = len + CRC_BYTES, go to BODY.
  - BODY: emit bytes, decrementing remaining. On the byte that brings remaining to 0, pkt_done=1 and pkt_err=0, go to SEARCH.
- Edge cases:
  - len=0: BODY emits exactly CRC_BYTES bytes.
  - Return to SEARCH clears sr and the fill counter, so no match can complete on stale bits.
  - en=0 in any state: next cycle state=SEARCH, counters cleared, no pkt_done. An in-flight byte is discarded.
  - en=0 while bit_valid=1: the bit is ignored.
  - Async rst mid-frame: immediate return to reset values.
- Widths: popcount 6 bits, remaining 9 bits (max 255+3), bit counter 3 bits.

Decomposition:
- Shared package ble_rx_pkg: state enum (SEARCH, HDR0, HDR1, BODY), BLE_AA_ADV=32'h8E89BED6, WHITEN_TAP constant (position 4), AA_BITS=32.
- One sub-module: ble_whitening_lfsr (ports clk, rst, load, channel, step, wbit), registered, with the init/step rules above.
- Correlator popcount stays inline.

Test Plan:
1. dewhiten_en=0, AA=8E89BED6; stream preamble 0xAA, AA LSB-first, then bytes 02 03 11 22 33 AA BB CC, bits 16 clk apart -> aa_found once; byte_valid x8 with 02,03,11,22,33,AA,BB,CC; pkt_done=1 and pkt_err=0 on the CC byte.
2. MAX_MISMATCH=1: AA with bit 5 flipped -> aa_found and frame decoded; AA with bits 5 and 17 flipped -> no aa_found, no byte_valid.
3. channel=37, dewhiten_en=1; PDU 40 06 01 02 03 04 05 06 + 3 CRC, whitened by a bench golden model of the LFSR rule -> byte_out equals the unwhitened bytes, 11 bytes, pkt_done on the last.
4. MAX_LEN=37, header 02 FF -> byte_valid twice, pkt_done=1 and pkt_err=1 with the second byte; an immediately following valid frame is found and decoded.
5. Abort: rst low at payload byte 2 -> all outputs 0 at once; separately, en=0 at payload byte 2 -> no further byte_valid, no pkt_done; re-enable and resend -> frame decoded.
6. Back-to-back bits (bit_valid every clk) of the case 1 stream -> identical byte sequence. AA bits preceded by 31 random bits after reset -> no false aa_found before 32 bits are shifted.

Source files
------------

// File: rtl/ble_rx_pkg.sv
// Shared definitions for the BLE receive path: deframer state encoding,
// access-address constants and the whitening feedback tap position.
// No ports; imported by the deframer and its whitening LFSR.
package ble_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HDR0   = 2'd1,
    HDR1   = 2'd2,
    BODY   = 2'd3
  } rx_state_e;

  // Advertising-channel access address.
  localparam logic [31:0] BLE_AA_ADV = 32'h8E89BED6;

  // Whitening polynomial x^7 + x^4 + 1: the feedback bit also lands on position 4.
  localparam int WHITEN_TAP = 4;

  localparam int AA_BITS = 32;

endpackage

// File: rtl/ble_whitening_lfsr.sv
// BLE data whitening sequence generator (x^7 + x^4 + 1), seeded from the channel index.
// Latency: wbit is the current register tap; the register advances one position per step.
// Backpressure: none; load wins over step. Ports: clk, rst (async active-low),
//   load (seed from channel), channel[5:0], step (advance one bit), wbit (whitening bit).
module ble_whitening_lfsr
  import ble_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] channel,
  input  logic       step,
  output logic       wbit
);

  logic [6:0] w;
  logic [6:0] w_nxt;

  // Rotate towards the MSB; the bit leaving position 6 re-enters at 0 and is
  // also folded into the tap position.
  always_comb begin
    w_nxt             = {w[5:0], w[6]};
    w_nxt[WHITEN_TAP] = w[WHITEN_TAP-1] ^ w[6];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w <= '0;
    end else if (load) begin
      // Channel bits are loaded in reverse order: channel[5] sits at position 1.
      w <= {channel[0], channel[1], channel[2], channel[3], channel[4], channel[5], 1'b1};
    end else if (step) begin
      w <= w_nxt;
    end
  end

  assign wbit = w[6];

endmodule

// File: rtl/ble_aa_packet_deframer.sv
// BLE access-address correlator and PDU deframer: finds the AA within MAX_MISMATCH bit
// errors, dewhitens the PDU and emits it as LSB-first bytes (header, payload, CRC).
// Latency: aa_found/byte_valid/pkt_done are registered, one clk after the deciding bit.
// Backpressure: none; the stage advances only on bit_valid and en=0 drops any frame.
// Ports: clk, rst (async active-low), en, bit_valid, bit_in, access_addr, channel,
//   dewhiten_en in; aa_found, byte_out, byte_valid, pkt_done, pkt_err out.
module ble_aa_packet_deframer
  import ble_rx_pkg::*;
#(
  parameter int MAX_MISMATCH = 1,
  parameter int MAX_LEN      = 255,
  parameter int CRC_BYTES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic [31:0] access_addr,
  input  logic [5:0]  channel,
  input  logic        dewhiten_en,
  output logic        aa_found,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        pkt_done,
  output logic        pkt_err
);

  rx_state_e   state;
  logic [31:0] sr;
  logic [5:0]  fill;
  logic [2:0]  bcnt;
  logic [7:0]  bsh;
  logic [8:0]  remaining;

  logic [31:0] cand;
  logic [5:0]  pop;
  logic [5:0]  fill_nxt;
  logic        match;
  logic        in_frame;
  logic        wbit;
  logic        dbit;
  logic [7:0]  byte_nxt;

  // Window as it will look after this bit is shifted in.
  assign cand = {bit_in, sr[31:1]};

  always_comb begin
    pop = '0;
    for (int i = 0; i < AA_BITS; i++) begin
      pop = pop + 6'(cand[i] ^ access_addr[i]);
    end
  end

  // Fill counts bits shifted since entering SEARCH, including the current one;
  // a match needs a window made entirely of received bits.
  assign fill_nxt = (fill == 6'(AA_BITS)) ? fill : fill + 6'd1;
  assign match    = (fill_nxt == 6'(AA_BITS)) && (pop <= 6'(MAX_MISMATCH));

  assign in_frame = (state != SEARCH);
  assign dbit     = bit_in ^ (dewhiten_en & wbit);
  assign byte_nxt = {dbit, bsh[7:1]};

  ble_whitening_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (en & bit_valid & ~in_frame & match),
    .channel (channel),
    .step    (en & bit_valid & in_frame),
    .wbit    (wbit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEARCH;
      sr         <= '0;
      fill       <= '0;
      bcnt       <= '0;
      bsh        <= '0;
      remaining  <= '0;
      aa_found   <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      aa_found   <= 1'b0;
      byte_valid <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      if (!en) begin
        // Drop everything, including a partly assembled byte; no pkt_done.
        state     <= SEARCH;
        sr        <= '0;
        fill      <= '0;
        bcnt      <= '0;
        bsh       <= '0;
        remaining <= '0;
      end else if (bit_valid) begin
        if (!in_frame) begin
          if (match) begin
            // sr/fill are cleared here and stay frozen outside SEARCH, so the
            // next search always starts from an empty window.
            aa_found  <= 1'b1;
            state     <= HDR0;
            sr        <= '0;
            fill      <= '0;
            bcnt      <= '0;
            remaining <= '0;
          end else begin
            sr   <= cand;
            fill <= fill_nxt;
          end
        end else begin
          bsh  <= byte_nxt;
          bcnt <= bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            byte_out   <= byte_nxt;
            byte_valid <= 1'b1;
            case (state)
              HDR0: state <= HDR1;
              HDR1: begin
                if ({1'b0, byte_nxt} > 9'(MAX_LEN)) begin
                  pkt_done <= 1'b1;
                  pkt_err  <= 1'b1;
                  state    <= SEARCH;
                end else begin
                  remaining <= 9'(byte_nxt) + 9'(CRC_BYTES);
                  state     <= BODY;
                end
              end
              BODY: begin
                remaining <= remaining - 9'd1;
                if (remaining == 9'd1) begin
                  pkt_done <= 1'b1;
                  state    <= SEARCH;
                end
              end
              default: state <= SEARCH;
            endcase
          end
        end
      end
    end
  end

endmodule
